// File: rtl/mem_stage_ctrl_pkg.sv
// Shared encodings and default geometry for the MEM stage controller and its data array.
package mem_stage_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int WORD_LEN_DEF    = 32;
   localparam int ADDRESS_LEN_DEF = 32;
   localparam int DEPTH_DEF       = 64;
   localparam int BASE_ADDR_DEF   = 1024;
   localparam int WAIT_CYCLES_DEF = 2;

   // Wide enough for the largest wait-state setting (15).
   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_stage_ctrl_mem_array.sv
// Word-addressed data array split into byte lanes: per-byte write enable, registered read port.
module mem_array
   import mem_stage_ctrl_pkg::*;
#(
   parameter int WORD_LEN = WORD_LEN_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   localparam int NB      = WORD_LEN / 8,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [NB-1:0]       be,
   input  logic [AW-1:0]       addr,
   input  logic [WORD_LEN-1:0] wdata,
   input  logic                re,
   output logic [WORD_LEN-1:0] rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         logic [7:0] lane_q [DEPTH];
         logic [7:0] rd_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int w = 0; w < DEPTH; w++) lane_q[w] <= '0;
               rd_q <= '0;
            end else begin
               if (we && be[gi]) lane_q[addr] <= wdata[gi*8 +: 8];
               if (re)           rd_q         <= lane_q[addr];
            end
         end

         assign rdata[gi*8 +: 8] = rd_q;
      end
   endgenerate

endmodule

// File: rtl/mem_stage_ctrl.sv
// Multi-cycle MEM stage: wait-state FSM, address decode, byte/word access and the ready stall handshake.
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
#(
   parameter int WORD_LEN    = WORD_LEN_DEF,
   parameter int ADDRESS_LEN = ADDRESS_LEN_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int BASE_ADDR   = BASE_ADDR_DEF,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDRESS_LEN-1:0] pc_in,
   output logic [ADDRESS_LEN-1:0] pc,
   input  logic                   MEM_R_EN,
   input  logic                   MEM_W_EN,
   input  logic                   mem_byte,
   input  logic [ADDRESS_LEN-1:0] ALU_Res,
   input  logic [WORD_LEN-1:0]    Val_Rm,
   output logic [WORD_LEN-1:0]    memory_out,
   output logic                   ready,
   output logic                   addr_err
);

   localparam int NB = WORD_LEN / 8;
   localparam int AW = $clog2(DEPTH);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDRESS_LEN-1:0] addr_q, addr_d;
   logic [WORD_LEN-1:0]    wdata_q, wdata_d;
   logic                   byte_q, byte_d;
   logic                   wr_q, wr_d;
   logic                   addr_err_q, addr_err_d;
   // Describe how the last completed read is presented, so memory_out holds across stores.
   logic [1:0]             view_lane_q, view_lane_d;
   logic                   view_byte_q, view_byte_d;
   logic                   view_zero_q, view_zero_d;

   logic                   req, idle, fire, oor;
   logic [ADDRESS_LEN-1:0] sel_addr, off;
   logic [WORD_LEN-1:0]    sel_wdata, arr_wdata, rdata;
   logic                   sel_byte, sel_wr;
   logic                   arr_we, arr_re;
   logic [NB-1:0]          arr_be;
   logic [AW-1:0]          arr_addr;
   logic [7:0]             byte_val;

   always_comb begin
      req  = MEM_R_EN | MEM_W_EN;
      idle = (state_q == S_IDLE);

      // From IDLE the access may complete on this very edge, so decode the live inputs there.
      sel_addr  = idle ? ALU_Res  : addr_q;
      sel_wdata = idle ? Val_Rm   : wdata_q;
      sel_byte  = idle ? mem_byte : byte_q;
      sel_wr    = idle ? MEM_W_EN : wr_q;

      off = sel_addr - ADDRESS_LEN'(BASE_ADDR);
      oor = (sel_addr < ADDRESS_LEN'(BASE_ADDR))
         || ((off >> 2) >= ADDRESS_LEN'(DEPTH))
         || (!sel_byte && off[1:0] != 2'b00);

      arr_addr  = off[AW+1:2];
      arr_be    = sel_byte ? (NB'(1) << off[1:0]) : '1;
      arr_wdata = sel_byte ? {NB{sel_wdata[7:0]}} : sel_wdata;

      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      byte_d      = byte_q;
      wr_d        = wr_q;
      addr_err_d  = 1'b0;
      view_lane_d = view_lane_q;
      view_byte_d = view_byte_q;
      view_zero_d = view_zero_q;
      fire        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = ALU_Res;
               wdata_d = Val_Rm;
               byte_d  = mem_byte;
               wr_d    = MEM_W_EN;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  state_d = S_DONE;
                  fire    = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
               fire    = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      arr_we = fire && sel_wr && !oor;
      arr_re = fire && !sel_wr && !oor;

      if (fire) begin
         addr_err_d = oor;
         if (!sel_wr) begin
            view_lane_d = off[1:0];
            view_byte_d = sel_byte;
            view_zero_d = oor;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         byte_q      <= 1'b0;
         wr_q        <= 1'b0;
         addr_err_q  <= 1'b0;
         view_lane_q <= 2'd0;
         view_byte_q <= 1'b0;
         view_zero_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         byte_q      <= byte_d;
         wr_q        <= wr_d;
         addr_err_q  <= addr_err_d;
         view_lane_q <= view_lane_d;
         view_byte_q <= view_byte_d;
         view_zero_q <= view_zero_d;
      end
   end

   mem_array #(
      .WORD_LEN (WORD_LEN),
      .DEPTH    (DEPTH)
   ) u_mem_array (
      .clk   (clk),
      .rst   (rst),
      .we    (arr_we),
      .be    (arr_be),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .re    (arr_re),
      .rdata (rdata)
   );

   always_comb begin
      byte_val   = rdata[{view_lane_q, 3'b000} +: 8];
      memory_out = '0;
      if (!view_zero_q) begin
         if (view_byte_q) memory_out[7:0] = byte_val;
         else             memory_out      = rdata;
      end
   end

   assign ready    = idle ? ~req : (state_q == S_DONE);
   assign addr_err = addr_err_q;
   assign pc       = pc_in;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench: two instances (2 and 0 wait states) against a word-array reference model.
module tb_mem_stage_ctrl;

   localparam int DEPTH = 64;
   localparam int BASE  = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in [2];
   logic [31:0] pc    [2];
   logic [31:0] alu   [2];
   logic [31:0] val   [2];
   logic [31:0] mout  [2];
   logic        r_en  [2];
   logic        w_en  [2];
   logic        byt   [2];
   logic        ready [2];
   logic        aerr  [2];

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl_mem [2][DEPTH];
   logic [31:0] mdl_out [2];

   always #5 clk = ~clk;

   mem_stage_ctrl #(.WAIT_CYCLES(2)) dut_w2 (
      .clk(clk), .rst(rst), .pc_in(pc_in[0]), .pc(pc[0]),
      .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]), .mem_byte(byt[0]),
      .ALU_Res(alu[0]), .Val_Rm(val[0]), .memory_out(mout[0]),
      .ready(ready[0]), .addr_err(aerr[0])
   );

   mem_stage_ctrl #(.WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .rst(rst), .pc_in(pc_in[1]), .pc(pc[1]),
      .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]), .mem_byte(byt[1]),
      .ALU_Res(alu[1]), .Val_Rm(val[1]), .memory_out(mout[1]),
      .ready(ready[1]), .addr_err(aerr[1])
   );

   function automatic int wait_states(input int u);
      return (u == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic reset_model();
      for (int u = 0; u < 2; u++) begin
         mdl_out[u] = '0;
         for (int i = 0; i < DEPTH; i++) mdl_mem[u][i] = '0;
      end
   endtask

   task automatic scramble(input int u, input bit allow_req);
      r_en[u]  = allow_req ? 1'($urandom) : 1'b0;
      w_en[u]  = allow_req ? 1'($urandom) : 1'b0;
      byt[u]   = 1'($urandom);
      alu[u]   = $urandom;
      val[u]   = $urandom;
      pc_in[u] = $urandom;
   endtask

   // One complete access on unit u; the reference result comes from the address rules directly.
   task automatic access(input int u, input bit r, input bit w, input bit b,
                         input logic [31:0] a, input logic [31:0] d);
      logic [31:0] off;
      int          idx, lane;
      bit          oor;
      off  = a - 32'(BASE);
      idx  = int'(off >> 2);
      lane = int'(off % 4);
      oor  = (a < 32'(BASE)) || ((off >> 2) >= 32'(DEPTH)) || (!b && lane != 0);

      @(negedge clk);
      r_en[u] = r; w_en[u] = w; byt[u] = b; alu[u] = a; val[u] = d; pc_in[u] = $urandom;
      #1;
      chk($sformatf("u%0d ready_req a=%0d", u, a), 32'(ready[u]), 32'd0);
      chk($sformatf("u%0d pc_pass", u), pc[u], pc_in[u]);
      chk($sformatf("u%0d err_req", u), 32'(aerr[u]), 32'd0);
      for (int k = 1; k <= wait_states(u); k++) begin
         @(negedge clk);
         scramble(u, 1'b1);
         #1;
         chk($sformatf("u%0d ready_wait%0d", u, k), 32'(ready[u]), 32'd0);
         chk($sformatf("u%0d err_wait%0d", u, k), 32'(aerr[u]), 32'd0);
      end
      @(negedge clk);
      scramble(u, 1'b0);

      if (w) begin
         if (!oor) begin
            if (b)
               mdl_mem[u][idx] = (mdl_mem[u][idx] & ~(32'hFF << (8 * lane)))
                               | ((d & 32'hFF) << (8 * lane));
            else
               mdl_mem[u][idx] = d;
         end
      end else if (oor) begin
         mdl_out[u] = '0;
      end else if (b) begin
         mdl_out[u] = (mdl_mem[u][idx] >> (8 * lane)) & 32'hFF;
      end else begin
         mdl_out[u] = mdl_mem[u][idx];
      end

      #1;
      chk($sformatf("u%0d ready_done a=%0d", u, a), 32'(ready[u]), 32'd1);
      chk($sformatf("u%0d addr_err a=%0d", u, a), 32'(aerr[u]), 32'(oor));
      chk($sformatf("u%0d mem_out r=%0d w=%0d b=%0d a=%0d", u, r, w, b, a), mout[u], mdl_out[u]);
      $display("u%0d %s%s a=%0d d=%h out=%h err=%0d", u, w ? "WR" : "RD", b ? "B" : "W",
               a, d, mout[u], aerr[u]);
   endtask

   task automatic idle_cycle(input int u);
      @(negedge clk);
      r_en[u] = 1'b0; w_en[u] = 1'b0; alu[u] = $urandom; val[u] = $urandom;
      #1;
      chk($sformatf("u%0d ready_idle", u), 32'(ready[u]), 32'd1);
      chk($sformatf("u%0d hold_idle", u), mout[u], mdl_out[u]);
      chk($sformatf("u%0d err_idle", u), 32'(aerr[u]), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          u;
      bit          r, w;

      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         r_en[i] = 0; w_en[i] = 0; byt[i] = 0; alu[i] = '0; val[i] = '0; pc_in[i] = '0;
      end
      reset_model();
      repeat (2) @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d reset_ready", i), 32'(ready[i]), 32'd1);
         chk($sformatf("u%0d reset_out", i), mout[i], 32'd0);
         chk($sformatf("u%0d reset_err", i), 32'(aerr[i]), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Word store then load, byte store over it, then byte/word loads.
      access(0, 0, 1, 0, 32'd1028, 32'hDEADBEEF);
      access(0, 1, 0, 0, 32'd1028, 32'h0);
      access(0, 0, 1, 1, 32'd1029, 32'h000000AA);
      access(0, 1, 0, 0, 32'd1028, 32'h0);
      access(0, 1, 0, 1, 32'd1029, 32'h0);

      // Out-of-range accesses, then confirm the array is untouched.
      access(0, 1, 0, 0, 32'd1000, 32'h0);
      access(0, 1, 0, 0, 32'(BASE + 4 * DEPTH), 32'h0);
      access(0, 0, 1, 0, 32'd1030, 32'h11223344);
      access(0, 1, 0, 0, 32'd1028, 32'h0);
      idle_cycle(0);

      // Zero wait states: fill four words, then four back-to-back loads.
      for (int i = 0; i < 4; i++) access(1, 0, 1, 0, 32'(BASE + 4 * i), $urandom);
      for (int i = 0; i < 4; i++) access(1, 1, 0, 0, 32'(BASE + 4 * i), 32'h0);
      idle_cycle(1);

      // Both enables high behaves as a store; memory_out keeps the previous load.
      access(0, 1, 1, 0, 32'd1036, 32'd5);
      access(0, 1, 0, 0, 32'd1036, 32'h0);

      // Reset in the second wait cycle of a store aborts it.
      access(0, 0, 1, 0, 32'd1032, 32'hCAFEF00D);
      access(0, 1, 0, 0, 32'd1032, 32'h0);
      @(negedge clk);
      w_en[0] = 1'b1; r_en[0] = 1'b0; byt[0] = 1'b0; alu[0] = 32'd1032; val[0] = 32'h12345678;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      w_en[0] = 1'b0;
      reset_model();
      #1;
      chk("u0 rst_wait_ready", 32'(ready[0]), 32'd1);
      chk("u0 rst_wait_out", mout[0], 32'd0);
      chk("u0 rst_wait_err", 32'(aerr[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      access(0, 1, 0, 0, 32'd1032, 32'h0);
      access(0, 1, 0, 0, 32'd1036, 32'h0);

      // Randomized mix across both instances.
      for (int n = 0; n < 300; n++) begin
         u = int'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) begin
            idle_cycle(u);
         end else begin
            if ($urandom_range(0, 9) == 0)
               a = $urandom;
            else
               a = 32'(BASE - 8) + 32'($urandom_range(0, 4 * DEPTH + 15));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            r = 1'($urandom);
            w = 1'($urandom);
            if (!r && !w) r = 1'b1;
            access(u, r, w, 1'($urandom), a, $urandom);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Parametrised, multi-cycle data-memory stage for the ARM pipeline, placed between EXE and WB.
- Owns a word-addressed data array and adds programmable wait states and byte/word access.
- Raises a `ready` handshake that the hazard/freeze logic uses to stall upstream stages while an access is in flight.
- Passes the PC through unchanged.

Parameters:
- WORD_LEN, 32, data width in bits (multiple of 8).
- ADDRESS_LEN, 32, address and PC width.
- DEPTH, 64, number of words in the array (power of two).
- BASE_ADDR, 1024, byte address mapped to word 0.
- WAIT_CYCLES, 2, extra wait states per access (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- pc_in  in  ADDRESS_LEN  PC from EXE.
- pc  out  ADDRESS_LEN  pc_in, combinational pass-through.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- mem_byte  in  1  1 = byte access (LDRB/STRB), 0 = word access.
- ALU_Res  in  ADDRESS_LEN  byte address.
- Val_Rm  in  WORD_LEN  store data.
- memory_out  out  WORD_LEN  load result.
- ready  out  1  0 = stall the pipeline.
- addr_err  out  1  out-of-range flag, valid while ready=1 after an access.

Behaviour:
- **Reset.** Asynchronous. State=IDLE, wait counter=0, memory_out=0, addr_err=0, every array word=0. An in-flight access is aborted and no write occurs.
- **Request.** `req = MEM_R_EN | MEM_W_EN`. If both are high, the access is a write and memory_out keeps its old value.
- **Address decode.**
  - off = ALU_Res - BASE_ADDR, computed modulo 2^ADDRESS_LEN.
  - Word index = off >> 2.
  - Out of range when ALU_Res < BASE_ADDR or index >= DEPTH.
  - Word access with off[1:0] != 0 is also out of range.
- **FSM: IDLE, WAIT, DONE.**
  - IDLE: `ready = ~req` (combinational). On req, latch address, data, mode and type; load counter = WAIT_CYCLES. Go to WAIT, or straight to DONE when WAIT_CYCLES=0.
  - WAIT: ready=0; counter decrements each cycle; at counter==1 go to DONE.
  - Array access happens on the edge that enters DONE. Writes commit on that edge. Read data is registered into memory_out on that edge.
  - DONE: ready=1; memory_out and addr_err are valid. Next edge returns to IDLE unconditionally, because the pipeline advances on that edge.
- **Latency.** A request presented in cycle 0 holds ready low for cycles 0..WAIT_CYCLES. ready is high in cycle WAIT_CYCLES+1.
- **Back-to-back requests.** A request still present in the IDLE cycle after DONE is a new access; this is the normal case for consecutive loads/stores.
- **Byte mode, little-endian.** Lane = off[1:0].
  - Read: the selected byte is zero-extended into memory_out.
  - Write: only that byte of the word changes; the other bytes are preserved.
- **Out-of-range access.** Write suppressed; read returns 0; addr_err=1 in DONE only. addr_err is 0 in every other state.
- **Input stability.** Request inputs may change during WAIT; the latched copies are used.
- **Hold rule.** memory_out holds its value between reads; stores and idle cycles do not change it.
- **Reset during WAIT or DONE.** Returns to IDLE; ready follows the IDLE rule immediately after reset.

Decomposition:
- **Shared package/config include:**
  - state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - default WORD_LEN, ADDRESS_LEN, DEPTH, BASE_ADDR, WAIT_CYCLES;
  - counter width.
- **One sub-module, mem_array:**
  - DEPTH x WORD_LEN storage with async-reset clear;
  - synchronous write with per-byte enable;
  - registered read port with an enable.
- **mem_stage_ctrl keeps:** FSM, counter, address decode, byte lane select/extend, ready/addr_err generation.

Test Plan:
1. WAIT_CYCLES=2, MEM_W_EN, ALU_Res=1028, Val_Rm=32'hDEADBEEF, then MEM_R_EN at 1028 -> each access holds ready=0 for 3 cycles, then 1 cycle; read gives memory_out=32'hDEADBEEF, addr_err=0.
2. Byte store, ALU_Res=1029, Val_Rm=32'h000000AA, over that word; then word read at 1028 and byte read at 1029 -> word read 32'hDEADAAEF; byte read 32'h000000AA.
3. Read at 1000, read at 1024+4*DEPTH, word write at 1030 -> each ends with addr_err=1 in DONE; read returns 0; array is unchanged when re-read.
4. WAIT_CYCLES=0, four consecutive loads, one per address -> ready pattern 0,1,0,1,...; each DONE cycle shows the correct word.
5. Assert rst in the second WAIT cycle of a write to 1032 -> state IDLE, memory_out=0; a later read at 1032 returns 0.
6. MEM_R_EN and MEM_W_EN both high, ALU_Res=1036, Val_Rm=5 -> treated as write: memory_out unchanged; a later read at 1036 returns 5.
